// File: rtl/pistorm_pkg.sv
// Shared PiStorm definitions: bus watchdog state encodings, Pi register
// addresses and the watchdog default timing values.
package pistorm_pkg;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_BUSY    = 2'd1,
    WD_ABORT   = 2'd2,
    WD_HOLDOFF = 2'd3
  } wd_state_e;

  // Pi-side register map.
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Watchdog defaults, in E-clock ticks (1.41 us each).
  localparam int unsigned TXN_TIMEOUT_DEF = 64;
  localparam int unsigned ABORT_LEN_DEF   = 2;
  localparam int unsigned IDLE_W_DEF      = 20;

  // Internal counter widths.
  localparam int unsigned CYC_W   = 8;
  localparam int unsigned AB_W    = 3;
  localparam int unsigned FAULT_W = 4;

endpackage

// File: rtl/pistorm_sync2.sv
// Two-flop level synchroniser into the E-clock domain.
// Ports:
//   e_clock      E clock, rising edge
//   rst_overflow asynchronous active-high reset, forces both flops to RST_VAL
//   level        asynchronous input level
//   synced       synchronised copy of level (2 tick latency)
module pistorm_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic e_clock,
  input  logic rst_overflow,
  input  logic level,
  output logic synced
);

  logic meta;

  always_ff @(posedge e_clock or posedge rst_overflow) begin
    if (rst_overflow) begin
      meta   <= RST_VAL;
      synced <= RST_VAL;
    end else begin
      meta   <= level;
      synced <= meta;
    end
  end

endmodule

// File: rtl/pistorm_bus_watchdog.sv
// PiStorm 68K bus watchdog (E-clock domain).
// Aborts a bus transaction that stays pending longer than TXN_TIMEOUT ticks,
// counts aborts (saturating) and flags loss of Pi heartbeat after a long idle.
// Ports:
//   e_clock          E clock, all state on its rising edge
//   rst_overflow     asynchronous active-high reset
//   txn_in_progress  pending-transaction flag from the bus engine (async)
//   pistorm_active   PiStorm alive level (async)
//   m68k_reset_n     system reset level (async)
//   abort            force-terminate the current transaction
//   heartbeat_lost   sticky: no transaction for 2^IDLE_W-1 ticks while active
//   fault_count      saturating abort count since rst_overflow
//   wd_state         current watchdog state (debug)
// Optional (macro PISTORM_WDT_STATUS_EN):
//   clr_faults       async; its rising edge clears fault_count
//   status_word      {heartbeat_lost, abort, wd_state, fault_count, 8'd0}
module pistorm_bus_watchdog
  import pistorm_pkg::*;
#(
  parameter int unsigned TXN_TIMEOUT = TXN_TIMEOUT_DEF,
  parameter int unsigned ABORT_LEN   = ABORT_LEN_DEF,
  parameter int unsigned IDLE_W      = IDLE_W_DEF
) (
  input  logic               e_clock,
  input  logic               rst_overflow,
  input  logic               txn_in_progress,
  input  logic               pistorm_active,
  input  logic               m68k_reset_n,
`ifdef PISTORM_WDT_STATUS_EN
  input  logic               clr_faults,
  output logic [15:0]        status_word,
`endif
  output logic               abort,
  output logic               heartbeat_lost,
  output logic [FAULT_W-1:0] fault_count,
  output logic [1:0]         wd_state
);

  localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(TXN_TIMEOUT - 1);
  localparam logic [AB_W-1:0]    AB_LAST   = AB_W'(ABORT_LEN - 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = '1;
  localparam logic [FAULT_W-1:0] FAULT_MAX = '1;

  logic txn_s, act_s, rst_s_n;

  pistorm_sync2 #(.RST_VAL(1'b0)) u_sync_txn (
    .e_clock(e_clock), .rst_overflow(rst_overflow), .level(txn_in_progress), .synced(txn_s));
  pistorm_sync2 #(.RST_VAL(1'b0)) u_sync_act (
    .e_clock(e_clock), .rst_overflow(rst_overflow), .level(pistorm_active), .synced(act_s));
  pistorm_sync2 #(.RST_VAL(1'b1)) u_sync_rst (
    .e_clock(e_clock), .rst_overflow(rst_overflow), .level(m68k_reset_n), .synced(rst_s_n));

  logic clr_rise;
`ifdef PISTORM_WDT_STATUS_EN
  logic clr_s, clr_d;

  pistorm_sync2 #(.RST_VAL(1'b0)) u_sync_clr (
    .e_clock(e_clock), .rst_overflow(rst_overflow), .level(clr_faults), .synced(clr_s));

  always_ff @(posedge e_clock or posedge rst_overflow) begin
    if (rst_overflow) clr_d <= 1'b0;
    else              clr_d <= clr_s;
  end

  assign clr_rise    = clr_s & ~clr_d;
  assign status_word = {heartbeat_lost, abort, wd_state, fault_count, 8'd0};
`else
  assign clr_rise = 1'b0;
`endif

  wd_state_e          state, state_n;
  logic [CYC_W-1:0]   cyc_cnt, cyc_n;
  logic [AB_W-1:0]    ab_cnt, ab_n;
  logic [IDLE_W-1:0]  idle_cnt, idle_n;
  logic [FAULT_W-1:0] fault_n;
  logic               abort_n, hb_n, busy_entry, fault_inc;

  // State and output registers.
  always_ff @(posedge e_clock or posedge rst_overflow) begin
    if (rst_overflow) begin
      state          <= WD_IDLE;
      cyc_cnt        <= '0;
      ab_cnt         <= '0;
      idle_cnt       <= '0;
      fault_count    <= '0;
      abort          <= 1'b0;
      heartbeat_lost <= 1'b0;
    end else begin
      state          <= state_n;
      cyc_cnt        <= cyc_n;
      ab_cnt         <= ab_n;
      idle_cnt       <= idle_n;
      fault_count    <= fault_n;
      abort          <= abort_n;
      heartbeat_lost <= hb_n;
    end
  end

  // Next-state, counters and outputs.
  always_comb begin
    state_n    = state;
    cyc_n      = cyc_cnt;
    ab_n       = ab_cnt;
    idle_n     = idle_cnt;
    fault_n    = fault_count;
    hb_n       = heartbeat_lost;
    busy_entry = 1'b0;
    fault_inc  = 1'b0;

    if (!rst_s_n) begin
      // System reset releases the bus; fault history is kept.
      state_n = WD_IDLE;
      cyc_n   = '0;
      ab_n    = '0;
      idle_n  = '0;
    end else begin
      case (state)
        WD_IDLE: begin
          if (txn_s) begin
            state_n    = WD_BUSY;
            cyc_n      = '0;
            busy_entry = 1'b1;
          end
        end
        WD_BUSY, WD_HOLDOFF: begin
          // Completion (or engine release) beats a coincident timeout.
          if (!txn_s || !act_s) begin
            state_n = WD_IDLE;
          end else if (cyc_cnt == CYC_LAST) begin
            state_n   = WD_ABORT;
            ab_n      = '0;
            fault_inc = 1'b1;
          end else begin
            cyc_n = cyc_cnt + CYC_W'(1);
          end
        end
        WD_ABORT: begin
          if (ab_cnt == AB_LAST) begin
            state_n = WD_HOLDOFF;
            cyc_n   = '0;
          end else begin
            ab_n = ab_cnt + AB_W'(1);
          end
        end
        default: state_n = WD_IDLE;
      endcase

      if (busy_entry || !act_s)
        idle_n = '0;
      else if (state == WD_IDLE && idle_cnt != IDLE_MAX)
        idle_n = idle_cnt + IDLE_W'(1);
    end

    if (busy_entry)
      hb_n = 1'b0;
    else if (idle_n == IDLE_MAX)
      hb_n = 1'b1;

    if (clr_rise)
      fault_n = '0;
    else if (fault_inc && fault_count != FAULT_MAX)
      fault_n = fault_count + FAULT_W'(1);

    // abort follows the ABORT state one tick late, dropped at once by system reset.
    abort_n = (state == WD_ABORT) && rst_s_n;
  end

  assign wd_state = state;

endmodule

// File: tb/tb_pistorm_bus_watchdog.sv
// Scoreboard bench for pistorm_bus_watchdog: stimulus pushes the expected
// sequence of output changes {heartbeat_lost, abort, wd_state, fault_count}
// with the tick spacing between them; a monitor pops on every change.
module tb_pistorm_bus_watchdog;

  logic       e_clock = 1'b0;
  logic       rst_overflow = 1'b1;
  logic       txn_in_progress = 1'b0;
  logic       pistorm_active = 1'b1;
  logic       m68k_reset_n = 1'b1;
  logic       abort;
  logic       heartbeat_lost;
  logic [3:0] fault_count;
  logic [1:0] wd_state;
`ifdef PISTORM_WDT_STATUS_EN
  logic        clr_faults = 1'b0;
  logic [15:0] status_word;
`endif

  pistorm_bus_watchdog #(
    .TXN_TIMEOUT(64),
    .ABORT_LEN(2),
    .IDLE_W(6)
  ) dut (
    .e_clock(e_clock),
    .rst_overflow(rst_overflow),
    .txn_in_progress(txn_in_progress),
    .pistorm_active(pistorm_active),
    .m68k_reset_n(m68k_reset_n),
`ifdef PISTORM_WDT_STATUS_EN
    .clr_faults(clr_faults),
    .status_word(status_word),
`endif
    .abort(abort),
    .heartbeat_lost(heartbeat_lost),
    .fault_count(fault_count),
    .wd_state(wd_state)
  );

  always #5 e_clock = ~e_clock;

  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_ABORT = 2'd2, S_HOLD = 2'd3;

  typedef struct {
    logic [7:0] v;   // {hb, abort, state, fault}
    int         dt;  // ticks since previous change, 0 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  ticks = 0;
  bit  mon_en = 1'b0;
  int  exp_fault = 0;

  always @(posedge e_clock) ticks <= ticks + 1;

  task automatic push_ev(input logic [1:0] st, input logic ab, input int f,
                         input logic hb, input int dt);
    ev_t e;
    e.v  = {hb, ab, st, 4'(f)};
    e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic bump_fault();
    if (exp_fault < 15) exp_fault++;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) $display("FAIL %s got=%0d want=%0d", name, got, want);
    else passed++;
  endtask

  // Pulse txn_in_progress for n ticks, then leave a short idle gap.
  task automatic hold_txn(input int n);
    @(negedge e_clock);
    txn_in_progress = 1'b1;
    repeat (n) @(posedge e_clock);
    @(negedge e_clock);
    txn_in_progress = 1'b0;
    repeat (8) @(negedge e_clock);
  endtask

  // Expected changes for a txn of 65 ticks: one abort, then completion in HOLDOFF.
  task automatic push_short_timeout();
    push_ev(S_BUSY, 1'b0, exp_fault, 1'b0, 0);
    bump_fault();
    push_ev(S_ABORT, 1'b0, exp_fault, 1'b0, 64);
    push_ev(S_ABORT, 1'b1, exp_fault, 1'b0, 1);
    push_ev(S_HOLD,  1'b1, exp_fault, 1'b0, 1);
    push_ev(S_IDLE,  1'b0, exp_fault, 1'b0, 1);
  endtask

  // Monitor: every change of the observed tuple is one DUT output event.
  initial begin
    logic [7:0] prev, cur;
    bit         first;
    int         last_t;
    ev_t        e;
    first  = 1'b1;
    last_t = 0;
    prev   = '0;
    wait (mon_en);
    forever begin
      @(negedge e_clock);
      cur = {heartbeat_lost, abort, wd_state, fault_count};
      if (first || cur !== prev) begin
        first = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event got=%h want=none tick=%0d", cur, ticks);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v)
            $display("FAIL event got=%h want=%h tick=%0d", cur, e.v, ticks);
          else
            passed++;
          if (e.dt != 0) begin
            checks++;
            if (ticks - last_t != e.dt)
              $display("FAIL event_spacing got=%0d want=%0d tick=%0d", ticks - last_t, e.dt, ticks);
            else
              passed++;
          end
        end
        last_t = ticks;
        prev   = cur;
      end
    end
  end

  // Stimulus.
  initial begin
    push_ev(S_IDLE, 1'b0, 0, 1'b0, 0);
    repeat (3) @(posedge e_clock);
    #1 rst_overflow = 1'b0;
    mon_en = 1'b1;

    // Normal transaction.
    push_ev(S_BUSY, 1'b0, 0, 1'b0, 0);
    push_ev(S_IDLE, 1'b0, 0, 1'b0, 10);
    hold_txn(10);

    // Race: completion on the timeout tick wins.
    push_ev(S_BUSY, 1'b0, 0, 1'b0, 0);
    push_ev(S_IDLE, 1'b0, 0, 1'b0, 64);
    hold_txn(64);

    // Long timeout: abort, holdoff, second abort, then completion.
    push_ev(S_BUSY,  1'b0, 0, 1'b0, 0);
    push_ev(S_ABORT, 1'b0, 1, 1'b0, 64);
    push_ev(S_ABORT, 1'b1, 1, 1'b0, 1);
    push_ev(S_HOLD,  1'b1, 1, 1'b0, 1);
    push_ev(S_HOLD,  1'b0, 1, 1'b0, 1);
    push_ev(S_ABORT, 1'b0, 2, 1'b0, 63);
    push_ev(S_ABORT, 1'b1, 2, 1'b0, 1);
    push_ev(S_HOLD,  1'b1, 2, 1'b0, 1);
    push_ev(S_HOLD,  1'b0, 2, 1'b0, 1);
    push_ev(S_IDLE,  1'b0, 2, 1'b0, 17);
    exp_fault = 2;
    hold_txn(150);

    // One tick past the race boundary times out.
    push_short_timeout();
    hold_txn(65);

    // Saturation over 17 consecutive timeouts.
    for (int i = 0; i < 17; i++) begin
      push_short_timeout();
      hold_txn(65);
    end

    // System reset arriving as ABORT is entered: abort never rises.
    push_ev(S_BUSY,  1'b0, exp_fault, 1'b0, 0);
    bump_fault();
    push_ev(S_ABORT, 1'b0, exp_fault, 1'b0, 64);
    push_ev(S_IDLE,  1'b0, exp_fault, 1'b0, 1);
    @(negedge e_clock);
    txn_in_progress = 1'b1;
    repeat (65) @(posedge e_clock);
    @(negedge e_clock);
    m68k_reset_n = 1'b0;
    repeat (4) @(negedge e_clock);
    txn_in_progress = 1'b0;
    repeat (4) @(negedge e_clock);
    m68k_reset_n = 1'b1;
    repeat (6) @(negedge e_clock);

    // rst_overflow while abort is high clears everything asynchronously.
    push_ev(S_BUSY,  1'b0, exp_fault, 1'b0, 0);
    bump_fault();
    push_ev(S_ABORT, 1'b0, exp_fault, 1'b0, 64);
    push_ev(S_ABORT, 1'b1, exp_fault, 1'b0, 1);
    push_ev(S_IDLE,  1'b0, 0, 1'b0, 1);
    exp_fault = 0;
    @(negedge e_clock);
    txn_in_progress = 1'b1;
    repeat (68) @(posedge e_clock);
    @(negedge e_clock);
    #2 rst_overflow = 1'b1;
    #1;
    chk("async_rst_abort", int'(abort), 0);
    chk("async_rst_fault", int'(fault_count), 0);
    chk("async_rst_state", int'(wd_state), 0);
    chk("async_rst_hb", int'(heartbeat_lost), 0);
    txn_in_progress = 1'b0;
    @(posedge e_clock);
    #1 rst_overflow = 1'b0;

    // Heartbeat: 63 idle ticks after act_s settles, cleared by the next txn.
    push_ev(S_IDLE, 1'b0, 0, 1'b1, 65);
    repeat (75) @(negedge e_clock);
    push_ev(S_BUSY, 1'b0, 0, 1'b0, 0);
    push_ev(S_IDLE, 1'b0, 0, 1'b0, 10);
    hold_txn(10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge e_clock);
    chk("scoreboard_drain_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    repeat (30000) @(posedge e_clock);
    checks++;
    $display("FAIL global_timeout got=%0d ticks want<30000", ticks);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
